// File: rtl/calle_if.sv
// calle_if: tester-facing bundle of enable, pedestrian buttons and the two street lights
interface calle_if;
    logic       enb;
    logic       a_peatonal;
    logic       b_peatonal;
    logic [1:0] semaforo_a;
    logic [1:0] semaforo_b;

    modport master (output enb, a_peatonal, b_peatonal, input semaforo_a, semaforo_b);
    modport slave  (input enb, a_peatonal, b_peatonal, output semaforo_a, semaforo_b);
endinterface

// File: rtl/calle_ctrl.sv
// calle_ctrl: two-street traffic light sequencer with pedestrian-shortened greens
module calle_ctrl #(
    parameter int T_VERDE     = 10,
    parameter int T_MIN_VERDE = 4,
    parameter int T_AMARILLO  = 3,
    parameter int T_ROJO      = 2
) (
    input logic    clk,
    input logic    reset,
    calle_if.slave bus
);
    typedef enum logic [2:0] {ROJO_1, A_VERDE, A_AMARILLO, ROJO_2, B_VERDE, B_AMARILLO} state_t;

    localparam int T_MAX = (T_VERDE > T_AMARILLO)
                         ? ((T_VERDE > T_ROJO) ? T_VERDE : T_ROJO)
                         : ((T_AMARILLO > T_ROJO) ? T_AMARILLO : T_ROJO);
    localparam int TW = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam logic [TW-1:0] LV = TW'(T_VERDE - 1);
    localparam logic [TW-1:0] LA = TW'(T_AMARILLO - 1);
    localparam logic [TW-1:0] LR = TW'(T_ROJO - 1);
    localparam logic [TW-1:0] LM = TW'(T_MIN_VERDE - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pend_a_q, pend_a_d;
    logic            pend_b_q, pend_b_d;
    logic [1:0]      sem_a_q, sem_a_d;
    logic [1:0]      sem_b_q, sem_b_d;
    logic [TW-1:0]   lim;
    logic            cut;
    logic            go;

    // next state, timer and request latches; lights decoded from the next state so they flip with it
    always_comb begin
        lim      = (state_q == A_VERDE || state_q == B_VERDE) ? LV :
                   (state_q == A_AMARILLO || state_q == B_AMARILLO) ? LA : LR;
        cut      = (state_q == A_VERDE && (pend_a_q || bus.a_peatonal)) ||
                   (state_q == B_VERDE && (pend_b_q || bus.b_peatonal));
        go       = bus.enb && (timer_q == lim || (cut && timer_q >= LM));
        state_d  = !go ? state_q : (state_q == B_AMARILLO) ? ROJO_1 : state_t'(state_q + 3'd1);
        timer_d  = go ? '0 : bus.enb ? timer_q + TW'(1) : timer_q;
        pend_a_d = (state_q == A_VERDE) && !go && (pend_a_q || bus.a_peatonal);
        pend_b_d = (state_q == B_VERDE) && !go && (pend_b_q || bus.b_peatonal);
        sem_a_d  = (state_d == A_VERDE) ? 2'b01 : (state_d == A_AMARILLO) ? 2'b10 : 2'b11;
        sem_b_d  = (state_d == B_VERDE) ? 2'b01 : (state_d == B_AMARILLO) ? 2'b10 : 2'b11;
    end

    // state register with async clear to all-red
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ROJO_1;
            timer_q  <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            sem_a_q  <= 2'b11;
            sem_b_q  <= 2'b11;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            sem_a_q  <= sem_a_d;
            sem_b_q  <= sem_b_d;
        end
    end

    assign bus.semaforo_a = sem_a_q;
    assign bus.semaforo_b = sem_b_q;
endmodule

// File: tb/tb_calle_ctrl.sv
// tb_calle_ctrl: directed sequencing checks plus a random safety sweep
module tb_calle_ctrl;
    localparam logic [3:0] RR = 4'b1111;
    localparam logic [3:0] AG = 4'b0111;
    localparam logic [3:0] AY = 4'b1011;
    localparam logic [3:0] BG = 4'b1101;
    localparam logic [3:0] BY = 4'b1110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] sb[$];

    calle_if bus();

    calle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag, input logic e, input logic pa, input logic pb, input logic [3:0] exp);
        bus.enb = e;
        bus.a_peatonal = pa;
        bus.b_peatonal = pb;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        chk(tag, {bus.semaforo_a, bus.semaforo_b}, sb.pop_front());
    endtask

    task automatic run(input string tag, input logic e, input logic pa, input logic pb, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) tick(tag, e, pa, pb, exp);
    endtask

    initial begin
        bus.enb = 1'b1;
        bus.a_peatonal = 1'b0;
        bus.b_peatonal = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_hold", {bus.semaforo_a, bus.semaforo_b}, RR);
        reset = 1'b1;
        chk("reset_release", {bus.semaforo_a, bus.semaforo_b}, RR);
        run("rojo1_first", 1, 0, 0, RR, 1);
        for (int p = 0; p < 2; p++) begin
            run("free_a_verde", 1, 0, 0, AG, 10);
            run("free_a_amarillo", 1, 0, 0, AY, 3);
            run("free_rojo2", 1, 0, 0, RR, 2);
            run("free_b_verde", 1, 0, 0, BG, 10);
            run("free_b_amarillo", 1, 0, 0, BY, 3);
            run("free_rojo1", 1, 0, 0, RR, 2);
        end
        run("cut1_entry", 1, 0, 0, AG, 1);
        tick("cut1_pulse", 1, 1, 0, AG);
        run("cut1_green", 1, 0, 0, AG, 2);
        run("cut1_yellow", 1, 0, 0, AY, 3);
        run("cut1_rojo2", 1, 0, 0, RR, 2);
        run("cut1_b_verde", 1, 0, 0, BG, 10);
        run("cut1_b_amarillo", 1, 0, 0, BY, 3);
        run("cut1_rojo1", 1, 0, 0, RR, 2);
        run("cut6_green", 1, 0, 0, AG, 6);
        tick("cut6_pulse", 1, 1, 0, AY);
        run("cut6_yellow", 1, 0, 0, AY, 2);
        run("cut6_rojo2", 1, 0, 0, RR, 2);
        run("enb_b_verde", 1, 0, 0, BG, 10);
        run("enb_b_amarillo_in", 1, 0, 0, BY, 1);
        run("enb_frozen", 0, 0, 0, BY, 5);
        run("enb_resume", 1, 0, 0, BY, 2);
        run("enb_rojo1", 1, 0, 0, RR, 2);
        run("ign_a_verde", 1, 0, 1, AG, 10);
        run("ign_a_amarillo", 1, 0, 1, AY, 3);
        run("ign_rojo2", 1, 0, 1, RR, 2);
        run("held_b_verde", 1, 0, 1, BG, 4);
        run("held_b_amarillo", 1, 0, 0, BY, 3);
        run("held_rojo1", 1, 0, 0, RR, 2);
        run("both_green", 1, 0, 0, AG, 4);
        tick("both_pulse", 1, 1, 1, AY);
        run("both_yellow", 1, 0, 0, AY, 2);
        run("both_rojo2", 1, 0, 0, RR, 2);
        run("both_b_full", 1, 0, 0, BG, 10);
        run("both_b_amarillo", 1, 0, 0, BY, 3);
        run("both_rojo1", 1, 0, 0, RR, 2);
        run("mid_a_verde", 1, 0, 0, AG, 3);
        reset = 1'b0;
        #1;
        chk("reset_async", {bus.semaforo_a, bus.semaforo_b}, RR);
        run("reset_held", 1, 1, 1, RR, 2);
        reset = 1'b1;
        run("restart_rojo1", 1, 0, 0, RR, 1);
        run("restart_a_verde", 1, 0, 0, AG, 10);
        run("restart_a_amarillo", 1, 0, 0, AY, 1);
        for (int i = 0; i < 200; i++) begin
            bus.enb = 1'($urandom_range(0, 1));
            bus.a_peatonal = 1'($urandom_range(0, 1));
            bus.b_peatonal = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("safe_both_go", {3'b000, bus.semaforo_a != 2'b11 && bus.semaforo_b != 2'b11}, 4'h0);
            chk("safe_off_code", {2'b00, bus.semaforo_a == 2'b00, bus.semaforo_b == 2'b00}, 4'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calle_ctrl.md
Name: calle_ctrl

Overview:
- Two-street traffic-light controller for a single intersection (street A, street B); each street has a pedestrian request button.
- Sequences green/yellow/all-red phases from enabled clock cycles; a pedestrian request shortens the current street's green.
- Standalone block, driven directly by the tester; no upstream or downstream handshakes.

Parameters:
- T_VERDE, 10, full green duration in enabled cycles (≥2).
- T_MIN_VERDE, 4, minimum green before a pedestrian request can cut it (1..T_VERDE).
- T_AMARILLO, 3, yellow duration in enabled cycles (≥1).
- T_ROJO, 2, all-red clearance duration in enabled cycles (≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enb  input  1  advance enable; when 0, FSM and timer freeze.
- a_peatonal  input  1  pedestrian request to cross street A.
- b_peatonal  input  1  pedestrian request to cross street B.
- semaforo_a  output  2  street A light: 00 off (unused), 01 green, 10 yellow, 11 red.
- semaforo_b  output  2  street B light, same encoding.

Behaviour:
- One clock; reset is asynchronous and active-low.
- States and outputs (A/B):
  - ROJO_1: 11/11
  - A_VERDE: 01/11
  - A_AMARILLO: 10/11
  - ROJO_2: 11/11
  - B_VERDE: 11/01
  - B_AMARILLO: 11/10
- Transition order: ROJO_1 → A_VERDE → A_AMARILLO → ROJO_2 → B_VERDE → B_AMARILLO → ROJO_1.
- Outputs are decoded from the state register only (Moore); they change on the same edge as the state.
- reset=0 forces, immediately and regardless of clk/enb:
  - state = ROJO_1, timer = 0, both request latches = 0
  - outputs 11/11
- Reset mid-cycle always restarts the sequence at ROJO_1.
- Timer:
  - Increments only on edges with enb=1.
  - A state of duration T lasts exactly T enabled cycles; the timer clears to 0 on every state change.
  - enb=0 holds state, timer and outputs.
  - Width is sized for the largest parameter; no wrap-around within a state.
- Request latches:
  - pend_a sets on any edge where a_peatonal=1 and state=A_VERDE; pend_b is the same for b_peatonal and B_VERDE.
  - Sampling ignores enb.
  - Requests in any other state are ignored (that street is already non-green or ending).
  - A latch clears when its street leaves green.
- Green exit (A_VERDE; B_VERDE is symmetric), on an enabled edge:
  - Normal: timer = T_VERDE-1.
  - Early: pend_a=1 (or a_peatonal=1 this edge) and timer ≥ T_MIN_VERDE-1.
- Request arriving after the minimum: green ends on the next enabled edge.
- Simultaneous a_peatonal and b_peatonal: only the button of the currently green street has effect.
- Never both streets non-red; every green is preceded by all-red clearance.

Test Plan:
- Reset: assert reset=0 mid-A_VERDE → outputs 11/11 immediately. Release with enb=1 → 2 cycles 11/11, then A green (01/11).
- Free run, enb=1, no buttons (defaults):
  - From reset release: A green 10 cycles → 10/11 for 3 → 11/11 for 2 → B green 10 → 11/10 for 3 → 11/11 for 2.
  - Period 30 cycles, repeats.
- Pedestrian cut: a_peatonal pulsed 1 cycle at A green cycle 1 → A green lasts exactly 4 cycles, then yellow. Pulse at cycle 6 → yellow follows on the next edge.
- enb gating: drop enb for 5 cycles during B yellow → outputs frozen at 11/10; yellow completes its remaining cycles after enb returns. Total yellow = 3 enabled cycles.
- Ignored requests: b_peatonal held 1 during the whole A phase → no effect, B green still full 10 cycles (latch not set before B_VERDE). Continuing to hold it into B_VERDE cuts B green to 4 cycles.
- Safety check: over 200 random cycles of enb/a_peatonal/b_peatonal:
  - never 01 or 10 on both streets simultaneously
  - code 00 never appears.
